// File: rtl/branch_history_predictor.sv
// ============================================================================
// Module   : branch_history_predictor
// Brief    : Bimodal 2-bit counter table plus tagged BTB for fetch-stage
//            direction/target prediction, trained by resolved EX branches.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_history_predictor #(
  parameter int         INDEX_W  = 4,
  parameter int         TAG_W    = 8,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_F,
  output logic        branch_decision,
  output logic [31:0] predict_target_F,
  input  logic        update_en_EX,
  input  logic [31:0] pc_EX,
  input  logic        taken_EX,
  input  logic [31:0] target_EX,
  input  logic        pred_taken_EX,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_W;

  logic [1:0]       r_cnt    [ENTRIES];
  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];
  logic [31:0]      r_branch_count;
  logic [31:0]      r_mispredict_count;

  logic [INDEX_W-1:0] w_rd_idx;
  logic [TAG_W-1:0]   w_rd_tag;
  logic [INDEX_W-1:0] w_up_idx;
  logic [TAG_W-1:0]   w_up_tag;
  logic               w_hit;
  logic [1:0]         w_cnt_next;

  assign w_rd_idx = pc_F[INDEX_W+1:2];
  assign w_rd_tag = pc_F[INDEX_W+TAG_W+1:INDEX_W+2];
  assign w_up_idx = pc_EX[INDEX_W+1:2];
  assign w_up_tag = pc_EX[INDEX_W+TAG_W+1:INDEX_W+2];

  // Direction is only trusted on a BTB tag hit; the counter itself is untagged.
  assign w_hit            = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
  assign branch_decision  = w_hit && r_cnt[w_rd_idx][1];
  assign predict_target_F = branch_decision ? r_target[w_rd_idx] : 32'd0;

  always_comb begin
    w_cnt_next = r_cnt[w_up_idx];
    if (taken_EX) begin
      if (r_cnt[w_up_idx] != 2'b11) w_cnt_next = r_cnt[w_up_idx] + 2'b01;
    end else begin
      if (r_cnt[w_up_idx] != 2'b00) w_cnt_next = r_cnt[w_up_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_cnt[i]    <= CNT_INIT;
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= 32'd0;
      end
      r_branch_count     <= 32'd0;
      r_mispredict_count <= 32'd0;
    end else if (update_en_EX) begin
      r_cnt[w_up_idx] <= w_cnt_next;
      // Not-taken outcomes leave the BTB entry in place.
      if (taken_EX) begin
        r_valid[w_up_idx]  <= 1'b1;
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= target_EX;
      end
      r_branch_count <= r_branch_count + 32'd1;
      if (pred_taken_EX != taken_EX) r_mispredict_count <= r_mispredict_count + 32'd1;
    end
  end

  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

endmodule

`default_nettype wire

// File: tb/tb_branch_history_predictor.sv
// ============================================================================
// Module   : tb_branch_history_predictor
// Brief    : Vector-table and scoreboard bench for branch_history_predictor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_history_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_F;
  logic        branch_decision;
  logic [31:0] predict_target_F;
  logic        update_en_EX;
  logic [31:0] pc_EX;
  logic        taken_EX;
  logic [31:0] target_EX;
  logic        pred_taken_EX;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  branch_history_predictor dut (
    .clk              (clk),
    .rst              (rst),
    .pc_F             (pc_F),
    .branch_decision  (branch_decision),
    .predict_target_F (predict_target_F),
    .update_en_EX     (update_en_EX),
    .pc_EX            (pc_EX),
    .taken_EX         (taken_EX),
    .target_EX        (target_EX),
    .pred_taken_EX    (pred_taken_EX),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        upd;
    logic [31:0] pc_ex;
    logic        taken;
    logic [31:0] tgt_ex;
    logic        pred;
    logic [31:0] pc_f;
    logic        exp_dec;
    logic [31:0] exp_tgt;
    logic [31:0] exp_bc;
    logic [31:0] exp_mc;
  } vec_t;

  typedef struct {
    logic        dec;
    logic [31:0] tgt;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(logic upd, logic [31:0] pc_ex, logic taken, logic [31:0] tgt_ex,
                              logic pred, logic [31:0] pc_f, logic exp_dec, logic [31:0] exp_tgt,
                              logic [31:0] exp_bc, logic [31:0] exp_mc);
    vec_t v;
    v.upd = upd; v.pc_ex = pc_ex; v.taken = taken; v.tgt_ex = tgt_ex; v.pred = pred;
    v.pc_f = pc_f; v.exp_dec = exp_dec; v.exp_tgt = exp_tgt; v.exp_bc = exp_bc; v.exp_mc = exp_mc;
    return v;
  endfunction

  task automatic cmp(string name, int id, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h expected=%h", name, id, act, exp);
    end
  endtask

  // Pop the oldest expectation and compare it against what the DUT presents now.
  task automatic sb_check(string name, int id);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s[%0d] scoreboard empty got=0 expected=1", name, id);
      return;
    end
    e = sb.pop_front();
    cmp({name, ".dec"}, id, {31'd0, branch_decision}, {31'd0, e.dec});
    cmp({name, ".tgt"}, id, predict_target_F, e.tgt);
    cmp({name, ".bc"},  id, branch_count, e.bc);
    cmp({name, ".mc"},  id, mispredict_count, e.mc);
  endtask

  // Drive one cycle of stimulus after the falling edge; prediction is sampled before the
  // next rising edge, so it reflects state from before this cycle's update.
  task automatic apply(string name, int id, vec_t v);
    exp_t e;
    @(negedge clk);
    update_en_EX  = v.upd;
    pc_EX         = v.pc_ex;
    taken_EX      = v.taken;
    target_EX     = v.tgt_ex;
    pred_taken_EX = v.pred;
    pc_F          = v.pc_f;
    e.dec = v.exp_dec; e.tgt = v.exp_tgt; e.bc = v.exp_bc; e.mc = v.exp_mc;
    sb.push_back(e);
    #1;
    sb_check(name, id);
  endtask

  vec_t vecs[21];

  initial begin
    rst = 1'b0; pc_F = 32'h100; update_en_EX = 1'b0; pc_EX = 32'd0;
    taken_EX = 1'b0; target_EX = 32'd0; pred_taken_EX = 1'b0;

    //            upd pc_ex    tk tgt_ex      pr pc_f     dec tgt        bc  mc
    vecs[0]  = mk(1, 32'h100, 1, 32'h40,   0, 32'h100, 0, 32'h0,    0, 0);
    vecs[1]  = mk(1, 32'h100, 1, 32'h40,   1, 32'h100, 1, 32'h40,   1, 1);
    vecs[2]  = mk(0, 32'h0,   0, 32'h0,    0, 32'h100, 1, 32'h40,   2, 1);
    vecs[3]  = mk(1, 32'h100, 0, 32'h0,    1, 32'h100, 1, 32'h40,   2, 1);
    vecs[4]  = mk(1, 32'h100, 0, 32'h0,    1, 32'h100, 1, 32'h40,   3, 2);
    vecs[5]  = mk(1, 32'h100, 0, 32'h0,    0, 32'h100, 0, 32'h0,    4, 3);
    vecs[6]  = mk(1, 32'h100, 0, 32'h0,    0, 32'h100, 0, 32'h0,    5, 3);
    vecs[7]  = mk(0, 32'h0,   0, 32'h0,    0, 32'h100, 0, 32'h0,    6, 3);
    vecs[8]  = mk(1, 32'h100, 1, 32'h40,   0, 32'h140, 0, 32'h0,    6, 3);
    vecs[9]  = mk(1, 32'h100, 1, 32'h40,   0, 32'h140, 0, 32'h0,    7, 4);
    vecs[10] = mk(0, 32'h0,   0, 32'h0,    0, 32'h140, 0, 32'h0,    8, 5);
    vecs[11] = mk(0, 32'h0,   0, 32'h0,    0, 32'h100, 1, 32'h40,   8, 5);
    vecs[12] = mk(1, 32'h140, 1, 32'h80,   0, 32'h140, 0, 32'h0,    8, 5);
    vecs[13] = mk(0, 32'h0,   0, 32'h0,    0, 32'h140, 1, 32'h80,   9, 6);
    vecs[14] = mk(0, 32'h0,   0, 32'h0,    0, 32'h100, 0, 32'h0,    9, 6);
    vecs[15] = mk(0, 32'h0,   0, 32'h0,    0, 32'h143, 1, 32'h80,   9, 6);
    vecs[16] = mk(0, 32'h140, 0, 32'hDEAD, 1, 32'h140, 1, 32'h80,   9, 6);
    vecs[17] = mk(0, 32'h140, 0, 32'hBEEF, 0, 32'h140, 1, 32'h80,   9, 6);
    vecs[18] = mk(1, 32'h204, 1, 32'h1234, 1, 32'h204, 0, 32'h0,    9, 6);
    vecs[19] = mk(0, 32'h0,   0, 32'h0,    0, 32'h204, 1, 32'h1234, 10, 6);
    vecs[20] = mk(0, 32'h0,   0, 32'h0,    0, 32'h140, 1, 32'h80,   10, 6);

    #3;
    cmp("reset_dec", 0, {31'd0, branch_decision}, 32'd0);
    cmp("reset_bc",  0, branch_count, 32'd0);
    cmp("reset_mc",  0, mispredict_count, 32'd0);
    #9 rst = 1'b1;

    for (int i = 0; i < 16; i++)
      apply("sweep", i, mk(0, 0, 0, 0, 0, 32'h100 + (i << 2), 0, 32'h0, 0, 0));

    for (int i = 0; i < 21; i++)
      apply("vec", i, vecs[i]);

    // Asynchronous reset while an update is being presented on a trained table.
    @(negedge clk);
    update_en_EX = 1'b1; pc_EX = 32'h140; taken_EX = 1'b1; target_EX = 32'h99; pred_taken_EX = 1'b0;
    pc_F = 32'h140;
    #2 rst = 1'b0;
    #1;
    cmp("rst_mid_dec", 0, {31'd0, branch_decision}, 32'd0);
    cmp("rst_mid_tgt", 0, predict_target_F, 32'd0);
    cmp("rst_mid_bc",  0, branch_count, 32'd0);
    cmp("rst_mid_mc",  0, mispredict_count, 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    update_en_EX = 1'b0;

    for (int i = 0; i < 16; i++)
      apply("post_rst", i, mk(0, 0, 0, 0, 0, 32'h140 + (i << 2), 0, 32'h0, 0, 0));
    apply("post_rst_204", 0, mk(0, 0, 0, 0, 0, 32'h204, 0, 32'h0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
